// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor: persistence-filtered OR of stream/instance block signals.
// It also latches the first offending channel and keeps a saturating event count.
module hls_deadlock_persist_monitor #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1,
  parameter int THRESH   = 16,
  parameter int CNT_W    = 8,
  parameter int ID_W     = 2,
  parameter int STICKY   = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_mask,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                block_raw,
  output logic [ID_W-1:0]     block_chan_id,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [7:0]          event_cnt
);

  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W:0]   THRESH_W  = (CNT_W+1)'(THRESH);
  localparam logic [ID_W-1:0]  INST_ID   = ID_W'(NUM_AXIS);

  logic                block_q, block_d;
  logic                block_raw_q, block_raw_d;
  logic [ID_W-1:0]     chan_id_q, chan_id_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [7:0]          event_cnt_q, event_cnt_d;

  logic [NUM_AXIS-1:0] masked_blk;
  logic                stall;
  logic [CNT_W:0]      cnt_inc;
  logic [CNT_W-1:0]    cnt_next;
  logic                detect;
  logic [ID_W-1:0]     first_id;

  always_comb begin
    masked_blk = axis_block_sigs & axis_mask;
    stall      = ((|masked_blk) | (|inst_block_sigs)) & ~(&inst_idle_sigs);

    // Widened increment so the saturation compare cannot overflow.
    cnt_inc  = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    cnt_next = '0;
    if (stall) begin
      cnt_next = (cnt_inc >= THRESH_W) ? THRESH_C : cnt_inc[CNT_W-1:0];
    end

    // Descending scan leaves the lowest blocked index; instance-only stalls report NUM_AXIS.
    first_id = INST_ID;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (masked_blk[i]) first_id = ID_W'(i);
    end

    detect = stall && (cnt_next == THRESH_C) && !clear && !block_q;
  end

  always_comb begin
    stall_cnt_d = clear ? '0 : cnt_next;
    block_raw_d = clear ? 1'b0 : stall;

    block_d = block_q;
    if (clear) begin
      block_d = 1'b0;
    end else if (detect) begin
      block_d = 1'b1;
    end else if ((STICKY == 0) && !stall) begin
      block_d = 1'b0;
    end

    chan_id_d = chan_id_q;
    if (clear) begin
      chan_id_d = '0;
    end else if (detect) begin
      chan_id_d = first_id;
    end

    // The event counter survives clear; only reset zeroes it.
    event_cnt_d = event_cnt_q;
    if (detect && (event_cnt_q != 8'hFF)) begin
      event_cnt_d = event_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      block_q     <= 1'b0;
      block_raw_q <= 1'b0;
      chan_id_q   <= '0;
      stall_cnt_q <= '0;
      event_cnt_q <= '0;
    end else begin
      block_q     <= block_d;
      block_raw_q <= block_raw_d;
      chan_id_q   <= chan_id_d;
      stall_cnt_q <= stall_cnt_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign block         = block_q;
  assign block_raw     = block_raw_q;
  assign block_chan_id = chan_id_q;
  assign stall_cnt     = stall_cnt_q;
  assign event_cnt     = event_cnt_q;

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Directed bench: four monitor instances (thresholds 4/16/4-sticky/1) share one stimulus stream.
module tb_hls_deadlock_persist_monitor;

  logic       clk = 1'b0;
  logic       reset, clear;
  logic [1:0] axb, mask;
  logic [0:0] idle, iblk;

  logic       a_blk, a_raw, b_blk, b_raw, s_blk, s_raw, t_blk, t_raw;
  logic [1:0] a_id, b_id, s_id, t_id;
  logic [7:0] a_cnt, b_cnt, s_cnt, t_cnt;
  logic [7:0] a_ev, b_ev, s_ev, t_ev;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hls_deadlock_persist_monitor #(.THRESH(4), .STICKY(0)) u_a (
    .clock(clk), .reset(reset), .axis_block_sigs(axb), .axis_mask(mask),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
    .block(a_blk), .block_raw(a_raw), .block_chan_id(a_id), .stall_cnt(a_cnt), .event_cnt(a_ev));

  hls_deadlock_persist_monitor #(.THRESH(16), .STICKY(0)) u_b (
    .clock(clk), .reset(reset), .axis_block_sigs(axb), .axis_mask(mask),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
    .block(b_blk), .block_raw(b_raw), .block_chan_id(b_id), .stall_cnt(b_cnt), .event_cnt(b_ev));

  hls_deadlock_persist_monitor #(.THRESH(4), .STICKY(1)) u_s (
    .clock(clk), .reset(reset), .axis_block_sigs(axb), .axis_mask(mask),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
    .block(s_blk), .block_raw(s_raw), .block_chan_id(s_id), .stall_cnt(s_cnt), .event_cnt(s_ev));

  hls_deadlock_persist_monitor #(.THRESH(1), .STICKY(0)) u_t (
    .clock(clk), .reset(reset), .axis_block_sigs(axb), .axis_mask(mask),
    .inst_idle_sigs(idle), .inst_block_sigs(iblk), .clear(clear),
    .block(t_blk), .block_raw(t_raw), .block_chan_id(t_id), .stall_cnt(t_cnt), .event_cnt(t_ev));

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; axb = 2'b00; mask = 2'b11; idle = 1'b0; iblk = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_block", {31'd0, a_blk}, 32'd0);
    chk("rst_raw", {31'd0, a_raw}, 32'd0);
    chk("rst_id", {30'd0, a_id}, 32'd0);
    chk("rst_cnt", {24'd0, a_cnt}, 32'd0);
    chk("rst_event", {24'd0, a_ev}, 32'd0);

    // Channel 1 blocked for THRESH=4 cycles
    axb = 2'b10;
    tick(3);
    chk("t1_cnt3", {24'd0, a_cnt}, 32'd3);
    chk("t1_block_early", {31'd0, a_blk}, 32'd0);
    chk("thr1_block", {31'd0, t_blk}, 32'd1);
    tick(1);
    chk("t1_cnt4", {24'd0, a_cnt}, 32'd4);
    chk("t1_block", {31'd0, a_blk}, 32'd1);
    chk("t1_id", {30'd0, a_id}, 32'd1);
    chk("t1_event", {24'd0, a_ev}, 32'd1);
    chk("t1_raw", {31'd0, a_raw}, 32'd1);
    chk("sticky_block", {31'd0, s_blk}, 32'd1);
    tick(2);
    chk("t1_cnt_sat", {24'd0, a_cnt}, 32'd4);
    chk("t1_event_once", {24'd0, a_ev}, 32'd1);
    axb = 2'b00;
    tick(1);
    chk("ns_deassert", {31'd0, a_blk}, 32'd0);
    chk("ns_id_hold", {30'd0, a_id}, 32'd1);
    chk("ns_cnt_zero", {24'd0, a_cnt}, 32'd0);
    chk("sticky_hold", {31'd0, s_blk}, 32'd1);

    // Clear pulse on the sticky monitor
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_sticky_block", {31'd0, s_blk}, 32'd0);
    chk("clr_sticky_id", {30'd0, s_id}, 32'd0);
    chk("clr_sticky_event", {24'd0, s_ev}, 32'd1);

    // Clear and stall in the same cycle
    axb = 2'b01; clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clr_stall_cnt", {24'd0, a_cnt}, 32'd0);
    chk("clr_stall_raw", {31'd0, a_raw}, 32'd0);
    tick(1);
    chk("clr_restart_cnt", {24'd0, a_cnt}, 32'd1);

    // 3 stalled, 1 gap, 3 stalled: never reaches THRESH
    axb = 2'b00;
    tick(1);
    axb = 2'b01;
    tick(3);
    chk("gap_cnt_a", {24'd0, a_cnt}, 32'd3);
    axb = 2'b00;
    tick(1);
    chk("gap_cnt_zero", {24'd0, a_cnt}, 32'd0);
    axb = 2'b01;
    tick(3);
    chk("gap_cnt_b", {24'd0, a_cnt}, 32'd3);
    chk("gap_block", {31'd0, a_blk}, 32'd0);
    chk("gap_event", {24'd0, a_ev}, 32'd1);
    axb = 2'b00;
    tick(1);

    // Instance block while all instances idle is suppressed
    iblk = 1'b1; idle = 1'b1;
    tick(20);
    chk("idle_block", {31'd0, b_blk}, 32'd0);
    chk("idle_cnt", {24'd0, b_cnt}, 32'd0);
    idle = 1'b0;
    tick(15);
    chk("inst_cnt15", {24'd0, b_cnt}, 32'd15);
    chk("inst_block_early", {31'd0, b_blk}, 32'd0);
    tick(1);
    chk("inst_block", {31'd0, b_blk}, 32'd1);
    chk("inst_id", {30'd0, b_id}, 32'd2);
    chk("inst_event", {24'd0, b_ev}, 32'd1);
    // Going idle mid-stall drops the condition next edge
    idle = 1'b1;
    tick(1);
    chk("idle_mid_cnt", {24'd0, b_cnt}, 32'd0);
    chk("idle_mid_block", {31'd0, b_blk}, 32'd0);
    iblk = 1'b0; idle = 1'b0;
    tick(1);

    // Masked-off channel never stalls
    mask = 2'b01; axb = 2'b10;
    tick(6);
    chk("mask_cnt", {24'd0, a_cnt}, 32'd0);
    chk("mask_raw", {31'd0, a_raw}, 32'd0);
    chk("mask_block", {31'd0, a_blk}, 32'd0);

    // Reset mid-count
    mask = 2'b11;
    tick(3);
    chk("pre_rst_cnt", {24'd0, a_cnt}, 32'd3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0; axb = 2'b00;
    chk("mid_rst_cnt", {24'd0, a_cnt}, 32'd0);
    chk("mid_rst_block", {31'd0, a_blk}, 32'd0);
    chk("mid_rst_raw", {31'd0, a_raw}, 32'd0);
    chk("mid_rst_id", {30'd0, a_id}, 32'd0);
    chk("mid_rst_event", {24'd0, a_ev}, 32'd0);
    tick(1);

    // THRESH=1: block is a one-cycle registered copy; events saturate at 255
    for (int i = 0; i < 300; i++) begin
      axb = 2'b01;
      tick(1);
      chk("thr1_follow_hi", {31'd0, t_blk}, 32'd1);
      chk("thr1_event", {24'd0, t_ev}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      tick(1);
      axb = 2'b00;
      tick(1);
      chk("thr1_follow_lo", {31'd0, t_blk}, 32'd0);
      tick(1);
    end
    chk("thr1_event_sat", {24'd0, t_ev}, 32'd255);
    chk("thr1_id", {30'd0, t_id}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
